// File: rtl/bf_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package bf_pkg;
  localparam int N_IN     = 3;
  localparam int N_VEC    = 8;
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } bf_state_t;

  function automatic logic [3:0] popcnt8(input logic [N_VEC-1:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < N_VEC; i++) s = s + 4'(v[i]);
    return s;
  endfunction
endpackage

// File: rtl/bf_settle_timer.sv
// Loadable down-counter; expired is high once the count reaches zero.
module bf_settle_timer
  import bf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  output logic                expired
);
  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/bf_sweep_ctrl.sv
// Walks all 8 input vectors of a 3-input function unit, captures its truth
// table and compares it against a golden table latched at start.
module bf_sweep_ctrl
  import bf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_VEC-1:0] expected,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             x,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic             pass,
  output logic [3:0]       mismatch_cnt
);
  // Timer is loaded with N-1 so that SETTLE spans exactly N cycles.
  localparam logic [SETTLE_W-1:0] LOAD_VAL =
    (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);

  bf_state_t        state, state_n;
  logic [N_IN-1:0]  idx;
  logic [N_IN-1:0]  vec;
  logic [N_VEC-1:0] exp_q;
  logic             res_vld;
  logic             tmr_load, tmr_en, tmr_exp;
  logic             res_on;

  bf_settle_timer u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .en       (tmr_en),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = APPLY;
      APPLY:   state_n = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (tmr_exp) state_n = SAMPLE;
      SAMPLE:  state_n = (idx == N_IN'(N_VEC - 1)) ? DONE : APPLY;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    tmr_load = (state == APPLY);
    tmr_en   = (state == SETTLE);
    res_on   = (state == DONE) || res_vld;
  end

  // vec mirrors idx while a vector is on the wires and drops to 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      vec       <= '0;
      exp_q     <= '0;
      table_out <= '0;
      res_vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx       <= '0;
          vec       <= '0;
          table_out <= '0;
          exp_q     <= expected;
          res_vld   <= 1'b0;
        end
        SAMPLE: begin
          table_out[idx] <= x;
          if (idx != N_IN'(N_VEC - 1)) begin
            idx <= idx + 1'b1;
            vec <= idx + 1'b1;
          end else begin
            vec <= '0;
          end
        end
        DONE:    res_vld <= 1'b1;
        default: ;
      endcase
    end
  end

  assign a            = vec[2];
  assign b            = vec[1];
  assign c            = vec[0];
  assign pass         = res_on && (table_out == exp_q);
  assign mismatch_cnt = res_on ? popcnt8(table_out ^ exp_q) : 4'd0;
endmodule

// File: tb/tb_bf_sweep_ctrl.sv
// Directed bench: u0 (settle 2, x=(a&b)|c) and u1 (settle 0, x=a^b^c).
module tb_bf_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] exp0 = '0, exp1 = '0;
  logic       a0, b0, c0, x0, busy0, done0, pass0;
  logic       a1, b1, c1, x1, busy1, done1, pass1;
  logic [7:0] tbl0, tbl1;
  logic [3:0] mm0, mm1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign x0 = (a0 & b0) | c0;
  assign x1 = a1 ^ b1 ^ c1;

  bf_sweep_ctrl #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .expected(exp0),
    .a(a0), .b(b0), .c(c0), .x(x0), .busy(busy0), .done(done0),
    .table_out(tbl0), .pass(pass0), .mismatch_cnt(mm0));

  bf_sweep_ctrl #(.SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1),
    .a(a1), .b(b1), .c(c1), .x(x1), .busy(busy1), .done(done1),
    .table_out(tbl1), .pass(pass1), .mismatch_cnt(mm1));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [7:0] exp_in;
    bit         toggle;   // drive expected to FF mid-sweep
    bit         repulse;  // pulse start on cycles 5 and 33
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] mm;
  } vec_t;

  vec_t vt[6];

  // Runs one u0 sweep; cycle n is the n-th cycle after the accepting edge.
  task automatic run_sweep(input vec_t v);
    int ndone, dcyc;
    logic dpass;
    logic [3:0] dmm;
    ndone = 0; dcyc = 0; dpass = 1'b0; dmm = '0;
    @(negedge clk);
    exp0 = v.exp_in;
    start0 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start0 = v.repulse && (n == 5 || n == 33);
      if (v.toggle && n == 10) exp0 = 8'hFF;
      if (n == 10) begin
        chk("busy_mid", int'(busy0), 1);
        chk("pass_busy_zero", int'({pass0, mm0}), 0);
      end
      if (done0) begin
        ndone++;
        if (ndone == 1) begin dcyc = n; dpass = pass0; dmm = mm0; end
      end
    end
    start0 = 1'b0;
    chk("done_cycle", dcyc, 33);
    chk("done_count", ndone, 1);
    chk("pass_at_done", int'(dpass), int'(v.pass));
    chk("mm_at_done", int'(dmm), int'(v.mm));
    chk("idle_after", int'({busy0, a0, b0, c0}), 0);
    chk("table_out", int'(tbl0), int'(v.tbl));
    chk("pass_hold", int'(pass0), int'(v.pass));
    chk("mm_hold", int'(mm0), int'(v.mm));
  endtask

  initial begin
    vt[0] = '{8'hEA, 1'b0, 1'b0, 8'hEA, 1'b1, 4'd0};
    vt[1] = '{8'h00, 1'b0, 1'b0, 8'hEA, 1'b0, 4'd5};
    vt[2] = '{8'hFF, 1'b0, 1'b0, 8'hEA, 1'b0, 4'd3};
    vt[3] = '{8'h15, 1'b0, 1'b0, 8'hEA, 1'b0, 4'd8};
    vt[4] = '{8'hEA, 1'b1, 1'b0, 8'hEA, 1'b1, 4'd0};
    vt[5] = '{8'hEB, 1'b0, 1'b1, 8'hEA, 1'b0, 4'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_u0", int'({a0, b0, c0, busy0, done0, pass0, mm0, tbl0}), 0);
    chk("reset_u1", int'({a1, b1, c1, busy1, done1, pass1, mm1, tbl1}), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_sweep(vt[i]);

    // Zero-settle instance: each vector on the wires for exactly 2 cycles.
    begin
      int ndone, dcyc, bad;
      ndone = 0; dcyc = 0; bad = 0;
      @(negedge clk);
      exp1 = 8'h96;
      start1 = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 24; n++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (n <= 16 && int'({a1, b1, c1}) != (n - 1) / 2) bad++;
        if (done1) begin ndone++; if (ndone == 1) dcyc = n; end
      end
      chk("s0_abc_seq_errs", bad, 0);
      chk("s0_done_cycle", dcyc, 17);
      chk("s0_done_count", ndone, 1);
      chk("s0_table", int'(tbl1), 'h96);
      chk("s0_pass", int'({pass1, mm1}), 'h10);
    end

    // Reset mid-sweep: immediate clear, no done, then a clean sweep.
    begin
      int ndone;
      ndone = 0;
      @(negedge clk);
      exp0 = 8'hEA;
      start0 = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 12; n++) begin
        @(negedge clk);
        start0 = 1'b0;
        if (done0) ndone++;
      end
      chk("pre_rst_busy", int'(busy0), 1);
      rst = 1'b1;
      #1;
      chk("rst_async_clear", int'({a0, b0, c0, busy0, done0, pass0, mm0, tbl0}), 0);
      repeat (2) begin
        @(negedge clk);
        if (done0) ndone++;
      end
      rst = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (done0) ndone++;
      end
      chk("rst_no_done", ndone, 0);
      chk("rst_idle", int'(busy0), 0);
      run_sweep(vt[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bf_sweep_ctrl.md
BF_SWEEP_CTRL -- requirements
Module: bf_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: number of wait cycles between applying a vector and sampling x; legal range 0..15.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port start  input  1  request one full sweep; accepted only in IDLE.
REQ-005 Port expected  input  8  golden truth table; bit k is the expected x for vector k.
REQ-006 Port a  output  1  drives the function-unit input a; equals idx[2].
REQ-007 Port b  output  1  drives the function-unit input b; equals idx[1].
REQ-008 Port c  output  1  drives the function-unit input c; equals idx[0].
REQ-009 Port x  input  1  function-unit output, sampled only in SAMPLE.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port done  output  1  single-cycle pulse at sweep end.
REQ-012 Port table_out  output  8  captured truth table; bit k is the x sampled for vector k.
REQ-013 Port pass  output  1  high when table_out equals the latched expected value.
REQ-014 Port mismatch_cnt  output  4  number of differing bits, range 0..8.

Function
REQ-015 The FSM SHALL have the states IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-016 IDLE SHALL move to APPLY on start=1, clear idx (3-bit) and table_out, and latch expected into an internal register.
REQ-017 APPLY SHALL last 1 cycle with {a,b,c}=idx, then go to SETTLE, or directly to SAMPLE when SETTLE_CYCLES=0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a settle counter, then go to SAMPLE.
REQ-019 SAMPLE SHALL last 1 cycle and write x into table_out[idx]; if idx=7 it goes to DONE, otherwise idx increments and the FSM returns to APPLY.
REQ-020 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-021 a, b and c SHALL be registered and hold the current vector from APPLY through SAMPLE.
REQ-022 a, b and c SHALL be 0 in IDLE and DONE.
REQ-023 Per-vector time SHALL be 2+SETTLE_CYCLES cycles.
REQ-024 done SHALL assert exactly 8*(2+SETTLE_CYCLES)+1 cycles after the edge that accepted start; with the default this is 33 cycles.
REQ-025 pass and mismatch_cnt SHALL become valid in the DONE cycle and hold until the next accepted start.
REQ-026 pass and mismatch_cnt SHALL read 0 while busy.
REQ-027 mismatch_cnt SHALL be the popcount of table_out XOR latched expected, computed at full 4-bit width with no saturation needed.
REQ-028 start while busy, including the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-029 Changes on expected after acceptance SHALL have no effect on the current sweep.
REQ-030 idx SHALL NOT wrap during a sweep; the sweep terminates at idx=7.
REQ-031 table_out SHALL hold its value after DONE until the next accepted start.

Reset
REQ-032 rst=1 SHALL immediately force the FSM to IDLE.
REQ-033 rst=1 SHALL zero idx, the settle counter, a, b, c, busy, done, table_out, pass, mismatch_cnt and the latched expected register.
REQ-034 rst asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-035 After rst deasserts, the first rising edge with start=1 SHALL begin a fresh sweep.

Structure
REQ-036 A shared package bf_pkg SHALL hold the state enum bf_state_t and the constants N_IN=3, N_VEC=8 and SETTLE_W=4.
REQ-037 One sub-module bf_settle_timer (load, count down, expire flag) SHALL implement the settle counter.
REQ-038 All other logic SHALL reside in bf_sweep_ctrl.

Verification
REQ-039 Scenario: DUT model x=(a&b)|c, expected=8'hEA, start pulse -> done after 33 cycles, table_out=8'hEA, pass=1, mismatch_cnt=0.
REQ-040 Scenario: same model, expected=8'h00 -> table_out=8'hEA, pass=0, mismatch_cnt=5.
REQ-041 Scenario: SETTLE_CYCLES=0, model x=a^b^c -> done after 17 cycles, table_out=8'h96; the a,b,c sequence is 000..111 with each vector held 2 cycles.
REQ-042 Scenario: start re-pulsed on cycles 5 and 33 of a sweep -> exactly one done pulse; state returns to IDLE.
REQ-043 Scenario: rst pulsed at cycle 12 of a sweep -> all outputs 0 asynchronously, no done pulse; a following start gives a correct full sweep.
REQ-044 Scenario: expected toggled to 8'hFF mid-sweep with model x=(a&b)|c and latched 8'hEA -> pass=1.
